// File: rtl/spike_generator_array.sv
// Array of periodic spike generators swept on each unit_pulse time-base tick.
// Optional SPIKEGEN_OVERRUN_CNT_EN adds a saturating dropped-pulse counter port.
module spike_generator_array #(
  parameter int unsigned Ngens   = 8,
  parameter int unsigned Nperiod = 16,
  parameter int unsigned Ntag    = 11,
  parameter int unsigned Nct     = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         unit_pulse,
  input  logic [$clog2(Ngens+1)-1:0]   conf_gens_used,
  input  logic [Ngens-1:0]             conf_gens_en,
  input  logic                         prog_v,
  input  logic [$clog2(Ngens)-1:0]     prog_gen_idx,
  input  logic [Nperiod-1:0]           prog_period,
  input  logic [Nperiod-1:0]           prog_ticks,
  input  logic [Ntag-1:0]              prog_tag,
  output logic                         prog_a,
`ifdef SPIKEGEN_OVERRUN_CNT_EN
  output logic [15:0]                  overrun_count,
`endif
  output logic                         out_v,
  output logic [Ntag-1:0]              out_tag,
  output logic [Nct-1:0]               out_ct,
  input  logic                         out_a
);

  localparam int unsigned UW = $clog2(Ngens + 1);
  localparam int unsigned IW = $clog2(Ngens);
  // One bit per encodable programming index; set only for existing generators
  localparam logic [(1<<IW)-1:0] IdxOkMask = (1<<IW)'((1 << Ngens) - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, EMIT} state_e;

  state_e             state_q, state_d;
  logic [UW-1:0]      idx_q, idx_d;
  logic               pend_q, pend_d;
  logic               out_v_q, out_v_d;
  logic [Ntag-1:0]    out_tag_q, out_tag_d;
  logic [Nct-1:0]     out_ct_q, out_ct_d;

  logic [Nperiod-1:0] period_q [Ngens];
  logic [Nperiod-1:0] ticks_q  [Ngens];
  logic [Ntag-1:0]    tag_q    [Ngens];

  logic [IW-1:0]      cur_idx;
  logic               idx_in_range;
  logic               last_idx;
  logic               consume;
  logic               tick_we;
  logic [Nperiod-1:0] tick_nxt;
  logic               prog_we;
  logic               drop_pulse;

  assign cur_idx      = idx_q[IW-1:0];
  assign idx_in_range = (idx_q < UW'(Ngens));
  assign last_idx     = (UW'(idx_q + 1'b1) >= conf_gens_used);

  assign prog_a  = prog_v && (state_q == IDLE) && !pend_q;
  assign prog_we = prog_a && IdxOkMask[prog_gen_idx];

  assign out_v   = out_v_q;
  assign out_tag = out_tag_q;
  assign out_ct  = out_ct_q;

  // Next-state, sweep step and output staging
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    out_v_d   = out_v_q;
    out_tag_d = out_tag_q;
    out_ct_d  = out_ct_q;
    consume   = 1'b0;
    tick_we   = 1'b0;
    tick_nxt  = ticks_q[cur_idx];

    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          consume = 1'b1;
          idx_d   = '0;
          state_d = (conf_gens_used == '0) ? IDLE : SWEEP;
        end
      end
      SWEEP: begin
        if (idx_q >= conf_gens_used) begin
          state_d = IDLE;
        end else if (idx_in_range && conf_gens_en[cur_idx] && (period_q[cur_idx] != '0)
                     && (ticks_q[cur_idx] == '0)) begin
          tick_we   = 1'b1;
          tick_nxt  = Nperiod'(period_q[cur_idx] - 1'b1);
          out_v_d   = 1'b1;
          out_tag_d = tag_q[cur_idx];
          out_ct_d  = Nct'(1);
          state_d   = EMIT;
        end else begin
          if (idx_in_range && conf_gens_en[cur_idx] && (period_q[cur_idx] != '0)) begin
            tick_we  = 1'b1;
            tick_nxt = Nperiod'(ticks_q[cur_idx] - 1'b1);
          end
          if (last_idx) state_d = IDLE;
          else          idx_d   = UW'(idx_q + 1'b1);
        end
      end
      EMIT: begin
        if (out_v_q && out_a) begin
          out_v_d = 1'b0;
          if (last_idx) begin
            state_d = IDLE;
          end else begin
            idx_d   = UW'(idx_q + 1'b1);
            state_d = SWEEP;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A pulse arriving while one is already queued is lost
    pend_d = (pend_q && !consume) || unit_pulse;
  end

  assign drop_pulse = unit_pulse && pend_q && !consume;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      out_v_q   <= 1'b0;
      out_tag_q <= '0;
      out_ct_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      out_v_q   <= out_v_d;
      out_tag_q <= out_tag_d;
      out_ct_q  <= out_ct_d;
    end
  end

  // Generator state: host writes only in IDLE, countdown updates only in SWEEP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(Ngens); i++) begin
        period_q[i] <= '0;
        ticks_q[i]  <= '0;
        tag_q[i]    <= '0;
      end
    end else begin
      if (prog_we) begin
        period_q[prog_gen_idx] <= prog_period;
        ticks_q[prog_gen_idx]  <= prog_ticks;
        tag_q[prog_gen_idx]    <= prog_tag;
      end
      if (tick_we) begin
        ticks_q[cur_idx] <= tick_nxt;
      end
    end
  end

`ifdef SPIKEGEN_OVERRUN_CNT_EN
  logic [15:0] ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (drop_pulse && (ovr_q != 16'hFFFF)) ovr_d = 16'(ovr_q + 1'b1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovr_q <= '0;
    else       ovr_q <= ovr_d;
  end

  assign overrun_count = ovr_q;
`else
  logic unused_drop;
  assign unused_drop = drop_pulse;
`endif

endmodule

// File: tb/tb_spike_generator_array.sv
// Directed bench for spike_generator_array: per-pulse spike tables plus
// hand-written handshake, queued-pulse and reset-abort sequences.
module tb_spike_generator_array;

  logic        clk = 1'b0;
  logic        reset;
  logic        unit_pulse;
  logic [3:0]  conf_gens_used;
  logic [7:0]  conf_gens_en;
  logic        prog_v;
  logic [2:0]  prog_gen_idx;
  logic [15:0] prog_period;
  logic [15:0] prog_ticks;
  logic [10:0] prog_tag;
  logic        prog_a;
  logic        out_v;
  logic [10:0] out_tag;
  logic [9:0]  out_ct;
  logic        out_a;
`ifdef SPIKEGEN_OVERRUN_CNT_EN
  logic [15:0] overrun_count;
`endif

  spike_generator_array dut (
    .clk            (clk),
    .reset          (reset),
    .unit_pulse     (unit_pulse),
    .conf_gens_used (conf_gens_used),
    .conf_gens_en   (conf_gens_en),
    .prog_v         (prog_v),
    .prog_gen_idx   (prog_gen_idx),
    .prog_period    (prog_period),
    .prog_ticks     (prog_ticks),
    .prog_tag       (prog_tag),
    .prog_a         (prog_a),
`ifdef SPIKEGEN_OVERRUN_CNT_EN
    .overrun_count  (overrun_count),
`endif
    .out_v          (out_v),
    .out_tag        (out_tag),
    .out_ct         (out_ct),
    .out_a          (out_a)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  used;
    logic [7:0]  en;
    int          n;
    logic [10:0] t0, t1, t2;
  } vec_t;

  vec_t        vecs[23];
  logic [10:0] got_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] u, input logic [7:0] e, input int n,
                              input logic [10:0] a, input logic [10:0] b, input logic [10:0] c);
    vec_t v;
    v.used = u; v.en = e; v.n = n; v.t0 = a; v.t1 = b; v.t2 = c;
    return v;
  endfunction

  task automatic prog(input logic [2:0] idx, input logic [15:0] per, input logic [15:0] tk,
                      input logic [10:0] tag);
    logic done;
    done = 1'b0;
    @(negedge clk);
    prog_v = 1'b1; prog_gen_idx = idx; prog_period = per; prog_ticks = tk; prog_tag = tag;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (prog_a) done = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    prog_v = 1'b0;
    check("prog_accepted", 32'(done), 32'd1);
  endtask

  // Issue one pulse, then ack every spike after a random 0..max_dly cycle hold
  task automatic pulse_collect(input int budget, input int max_dly);
    int          dly, cnt;
    logic        busy;
    logic [10:0] ht;
    logic [9:0]  hc;
    got_q.delete();
    busy = 1'b0; cnt = 0; dly = 0; ht = '0; hc = '0;
    @(negedge clk);
    unit_pulse = 1'b1; out_a = 1'b0;
    @(negedge clk);
    unit_pulse = 1'b0;
    for (int c = 0; c < budget; c++) begin
      out_a = 1'b0;
      if (out_v) begin
        if (!busy) begin
          busy = 1'b1; ht = out_tag; hc = out_ct; cnt = 0;
          dly = int'($urandom_range(max_dly, 0));
          check("spike_ct", 32'(out_ct), 32'd1);
        end else begin
          check("stable_tag", 32'(out_tag), 32'(ht));
          check("stable_ct", 32'(out_ct), 32'(hc));
        end
        if (cnt == dly) begin
          out_a = 1'b1;
          got_q.push_back(ht);
          busy = 1'b0;
        end else begin
          cnt++;
        end
      end
      @(negedge clk);
    end
    out_a = 1'b0;
    check("sweep_drained", 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input int i);
    logic [10:0] exp_t[3];
    exp_t[0] = vecs[i].t0; exp_t[1] = vecs[i].t1; exp_t[2] = vecs[i].t2;
    conf_gens_used = vecs[i].used;
    conf_gens_en   = vecs[i].en;
    pulse_collect(50, 10);
    check($sformatf("v%0d_count", i), 32'(got_q.size()), 32'(vecs[i].n));
    for (int k = 0; k < vecs[i].n; k++) begin
      if (k < got_q.size()) check($sformatf("v%0d_tag%0d", i, k), 32'(got_q[k]), 32'(exp_t[k]));
    end
  endtask

  initial begin
    logic seen, acked, saw_v;

    // gen0 {2,0,512} fires on odd pulses; gen1 {4,2,513} on pulses 3,7,11,...
    vecs[0]  = mk(2, 8'h03, 1, 512, 0, 0);
    vecs[1]  = mk(2, 8'h03, 0, 0, 0, 0);
    vecs[2]  = mk(2, 8'h03, 2, 512, 513, 0);
    vecs[3]  = mk(2, 8'h03, 0, 0, 0, 0);
    vecs[4]  = mk(2, 8'h03, 1, 512, 0, 0);
    vecs[5]  = mk(2, 8'h03, 0, 0, 0, 0);
    vecs[6]  = mk(2, 8'h03, 2, 512, 513, 0);
    vecs[7]  = mk(2, 8'h03, 0, 0, 0, 0);
    // gen0 disabled: gen1 keeps its period-4 cadence
    vecs[8]  = mk(2, 8'h02, 0, 0, 0, 0);
    vecs[9]  = mk(2, 8'h02, 0, 0, 0, 0);
    vecs[10] = mk(2, 8'h02, 1, 513, 0, 0);
    vecs[11] = mk(2, 8'h02, 0, 0, 0, 0);
    // only gen0 swept: gen1 frozen at ticks=2
    vecs[12] = mk(1, 8'h03, 1, 512, 0, 0);
    vecs[13] = mk(1, 8'h03, 0, 0, 0, 0);
    vecs[14] = mk(1, 8'h03, 1, 512, 0, 0);
    vecs[15] = mk(1, 8'h03, 0, 0, 0, 0);
    // gen1 resumes from held ticks=2
    vecs[16] = mk(2, 8'h03, 1, 512, 0, 0);
    vecs[17] = mk(2, 8'h03, 0, 0, 0, 0);
    vecs[18] = mk(2, 8'h03, 2, 512, 513, 0);
    vecs[19] = mk(2, 8'h03, 0, 0, 0, 0);
    // after queued pulse and gen2 {1,0,700} write
    vecs[20] = mk(3, 8'h07, 3, 512, 513, 700);
    vecs[21] = mk(3, 8'h07, 1, 700, 0, 0);
    vecs[22] = mk(3, 8'h07, 2, 512, 700, 0);

    reset = 1'b1; unit_pulse = 1'b0; conf_gens_used = '0; conf_gens_en = '0;
    prog_v = 1'b0; prog_gen_idx = '0; prog_period = '0; prog_ticks = '0; prog_tag = '0;
    out_a = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_v", 32'(out_v), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_ct", 32'(out_ct), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_out_v", 32'(out_v), 32'd0);

    prog(3'd0, 16'd2, 16'd0, 11'd512);
    prog(3'd1, 16'd4, 16'd2, 11'd513);

    for (int i = 0; i < 20; i++) run_vec(i);

    // Pulse with held ack: programming blocked during sweep, extra pulses queue/drop
    conf_gens_used = 4'd2; conf_gens_en = 8'h03;
    @(negedge clk); unit_pulse = 1'b1;
    @(negedge clk); unit_pulse = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (out_v) seen = 1'b1;
      else @(negedge clk);
    end
    check("hs_spike_seen", 32'(seen), 32'd1);
    check("hs_spike_tag", 32'(out_tag), 32'd512);
    prog_v = 1'b1; prog_gen_idx = 3'd2; prog_period = 16'd1; prog_ticks = 16'd0; prog_tag = 11'd700;
    for (int c = 0; c < 4; c++) begin
      #1 check("prog_a_blocked", 32'(prog_a), 32'd0);
      @(negedge clk);
    end
    unit_pulse = 1'b1; @(negedge clk);
    unit_pulse = 1'b0; @(negedge clk);
    unit_pulse = 1'b1; @(negedge clk);
    unit_pulse = 1'b0;
    check("hs_hold_v", 32'(out_v), 32'd1);
    check("hs_hold_tag", 32'(out_tag), 32'd512);
    #1 check("prog_a_blocked_pend", 32'(prog_a), 32'd0);
    @(negedge clk);
    out_a = 1'b1;
    @(negedge clk);
    out_a = 1'b0;
    acked = 1'b0; saw_v = 1'b0;
    for (int c = 0; c < 40 && !acked; c++) begin
      #1;
      if (out_v) saw_v = 1'b1;
      if (prog_a) acked = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    prog_v = 1'b0;
    check("hs_prog_acked", 32'(acked), 32'd1);
    check("hs_no_extra_spike", 32'(saw_v), 32'd0);
`ifdef SPIKEGEN_OVERRUN_CNT_EN
    check("overrun_count", 32'(overrun_count), 32'd1);
`endif

    for (int i = 20; i < 23; i++) run_vec(i);

    // Reset during EMIT aborts the spike and clears all generators
    conf_gens_used = 4'd3; conf_gens_en = 8'h07;
    @(negedge clk); unit_pulse = 1'b1;
    @(negedge clk); unit_pulse = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (out_v) seen = 1'b1;
      else @(negedge clk);
    end
    check("rst_emit_seen", 32'(seen), 32'd1);
    check("rst_emit_tag", 32'(out_tag), 32'd700);
    #1 reset = 1'b1;
    #1;
    check("async_rst_out_v", 32'(out_v), 32'd0);
    check("async_rst_out_tag", 32'(out_tag), 32'd0);
    check("async_rst_out_ct", 32'(out_ct), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    conf_gens_used = 4'd8; conf_gens_en = 8'hFF;
    pulse_collect(50, 0);
    check("cleared_no_spikes", 32'(got_q.size()), 32'd0);
    pulse_collect(50, 0);
    check("cleared_no_spikes2", 32'(got_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
